// File: rtl/demux8to1_3bit_frame.sv
// Registered 1-to-8 demultiplexer and frame assembler for 3-bit lanes.
// Staging lanes fill round-robin or by address; a full frame is published atomically on a..h.
module demux8to1_3bit_frame #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode,
    input  logic [2:0]       s,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h,
    output logic             frame_valid,
    output logic [7:0]       fill_mask,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned LANES = 8;

    logic [WIDTH-1:0] stage_q [LANES];
    logic [WIDTH-1:0] stage_d [LANES];
    logic [WIDTH-1:0] pub_q   [LANES];
    logic [WIDTH-1:0] pub_d   [LANES];
    logic [2:0]       ptr_q, ptr_d;
    logic [7:0]       mask_d;
    logic             mode_q, mode_d;
    logic             init_q;
    logic             fv_d;
    logic [CNT_W-1:0] cnt_d;
    logic             eff_mode, flush, wr, complete;
    logic [2:0]       lane;

    // init_q marks the first edge after reset, where mode_q is loaded without a flush
    always_comb begin
        eff_mode = init_q ? mode : mode_q;
        flush    = !init_q && (mode != mode_q);
        wr       = in_valid && !flush;
        lane     = eff_mode ? s : ptr_q;
        stage_d  = stage_q;
        pub_d    = pub_q;
        ptr_d    = ptr_q;
        mask_d   = fill_mask;
        mode_d   = mode;
        fv_d     = 1'b0;
        cnt_d    = frame_cnt;
        complete = 1'b0;
        if (flush) begin
            ptr_d  = 3'd0;
            mask_d = 8'd0;
        end else if (wr) begin
            stage_d[lane] = in_data;
            mask_d        = fill_mask | (8'(1) << lane);
            if (!eff_mode) begin
                ptr_d = ptr_q + 3'(1);
            end
            complete = eff_mode ? (mask_d == 8'hFF) : (ptr_q == 3'd7);
            // publish uses stage_d so the completing write is bypassed into its lane
            if (complete) begin
                pub_d  = stage_d;
                mask_d = 8'd0;
                ptr_d  = 3'd0;
                fv_d   = 1'b1;
                cnt_d  = frame_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                stage_q[i] <= '0;
                pub_q[i]   <= '0;
            end
            ptr_q       <= 3'd0;
            fill_mask   <= 8'd0;
            mode_q      <= 1'b0;
            init_q      <= 1'b1;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            stage_q     <= stage_d;
            pub_q       <= pub_d;
            ptr_q       <= ptr_d;
            fill_mask   <= mask_d;
            mode_q      <= mode_d;
            init_q      <= 1'b0;
            frame_valid <= fv_d;
            frame_cnt   <= cnt_d;
        end
    end

    assign a = pub_q[0];
    assign b = pub_q[1];
    assign c = pub_q[2];
    assign d = pub_q[3];
    assign e = pub_q[4];
    assign f = pub_q[5];
    assign g = pub_q[6];
    assign h = pub_q[7];

endmodule
